// File: rtl/mp_completion_manager_pkg.sv
// Shared types and field layout for the completion manager.
// Used by the FIFO, the interface and the top; no build options live here.
package mp_pkg;
  localparam int PID_W        = 9;
  localparam int JOBID_W      = 32;
  localparam int CMPL_REC_W   = 41;
  localparam int PID_LSB      = 32;
  localparam int JOBID_LSB    = 0;
  localparam int WB_VALID_BIT = 63;

  typedef enum logic [1:0] {IDLE, WB, IRQ} cmpl_state_e;

  typedef struct packed {
    logic [PID_W-1:0]   pid;
    logic [JOBID_W-1:0] jobid;
  } cmpl_rec_t;

  // 64-bit write-back word: valid flag on top, pid/jobid at their fixed offsets.
  function automatic logic [63:0] wb_word(cmpl_rec_t r);
    logic [63:0] w;
    w = '0;
    w[WB_VALID_BIT]            = 1'b1;
    w[PID_LSB +: PID_W]        = r.pid;
    w[JOBID_LSB +: JOBID_W]    = r.jobid;
    return w;
  endfunction
endpackage

// File: rtl/mp_completion_manager_if.sv
// Write-back request channel toward the host write-request arbiter.
interface mp_completion_manager_if;
  logic        wb_valid;
  logic        wb_ready;
  logic [63:0] wb_addr;
  logic [63:0] wb_data;

  modport master (output wb_valid, output wb_addr, output wb_data, input wb_ready);
  modport slave  (input wb_valid, input wb_addr, input wb_data, output wb_ready);
endinterface

// File: rtl/mp_completion_manager_fifo.sv
// Synchronous completion-record FIFO; pointers wrap naturally (DEPTH is a power of two).
module mp_cmpl_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 41
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             wdata_i,
  output logic [W-1:0]             rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/mp_completion_manager.sv
// Buffers scheduler completion records and drains each as one 64-bit host write-back.
// Build option MP_CMPL_IRQ_EN adds a per-completion interrupt handshake after each write-back.
module mp_completion_manager
  import mp_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int SLOT_SHIFT = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          complete_push_i,
  input  logic [CMPL_REC_W-1:0]         return_data_i,
  output logic                          complete_ready_o,
  input  logic [63:0]                   cmpl_base_addr_i,
  mp_completion_manager_if.master       wb,
  output logic [31:0]                   cmpl_count_o,
  output logic                          overflow_o
`ifdef MP_CMPL_IRQ_EN
  ,
  output logic                          irq_valid_o,
  input  logic                          irq_ready_i,
  output logic [PID_W-1:0]              irq_pid_o
`endif
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  cmpl_state_e            state_q;
  logic                   wb_valid_q;
  logic [63:0]            wb_addr_q, wb_data_q;
  logic [31:0]            cnt_q;
  logic                   overflow_q;
  logic                   fifo_pop, fifo_full, fifo_empty;
  logic [CMPL_REC_W-1:0]  fifo_rdata;
  logic [CNT_W-1:0]       fifo_count;
  cmpl_rec_t              head;
`ifdef MP_CMPL_IRQ_EN
  logic                   irq_valid_q;
  logic [PID_W-1:0]       irq_pid_q;
`endif

  mp_cmpl_fifo #(.DEPTH(FIFO_DEPTH), .W(CMPL_REC_W)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (complete_push_i),
    .pop_i   (fifo_pop),
    .wdata_i (return_data_i),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign head             = cmpl_rec_t'(fifo_rdata);
  // Ready follows the registered count only; a same-cycle pop does not free a slot early.
  assign complete_ready_o = (fifo_count < CNT_W'(FIFO_DEPTH));
  assign fifo_pop         = (state_q == IDLE) & ~fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overflow_q <= 1'b0;
    else if (complete_push_i & fifo_full) overflow_q <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wb_valid_q  <= 1'b0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      cnt_q       <= '0;
`ifdef MP_CMPL_IRQ_EN
      irq_valid_q <= 1'b0;
      irq_pid_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: if (!fifo_empty) begin
          wb_addr_q  <= cmpl_base_addr_i + ({55'b0, head.pid} << SLOT_SHIFT);
          wb_data_q  <= wb_word(head);
          wb_valid_q <= 1'b1;
          state_q    <= WB;
        end
        WB: if (wb.wb_ready) begin
          cnt_q      <= cnt_q + 32'd1;
          wb_valid_q <= 1'b0;
`ifdef MP_CMPL_IRQ_EN
          irq_valid_q <= 1'b1;
          irq_pid_q   <= wb_data_q[PID_LSB +: PID_W];
          state_q     <= IRQ;
`else
          state_q    <= IDLE;
`endif
        end
`ifdef MP_CMPL_IRQ_EN
        IRQ: if (irq_ready_i) begin
          irq_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wb.wb_valid    = wb_valid_q;
  assign wb.wb_addr     = wb_addr_q;
  assign wb.wb_data     = wb_data_q;
  assign cmpl_count_o   = cnt_q;
  assign overflow_o     = overflow_q;
`ifdef MP_CMPL_IRQ_EN
  assign irq_valid_o    = irq_valid_q;
  assign irq_pid_o      = irq_pid_q;
`endif
endmodule

// File: tb/tb_mp_completion_manager.sv
// Directed bench for mp_completion_manager; IRQ steps are built only with MP_CMPL_IRQ_EN.
module tb_mp_completion_manager;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        complete_push;
  logic [40:0] return_data;
  logic        complete_ready;
  logic [63:0] base;
  logic [31:0] cmpl_count;
  logic        overflow;
`ifdef MP_CMPL_IRQ_EN
  logic        irq_valid, irq_ready;
  logic [8:0]  irq_pid;
`endif

  mp_completion_manager_if wb_if ();

  mp_completion_manager #(.FIFO_DEPTH(16), .SLOT_SHIFT(3)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .complete_push_i  (complete_push),
    .return_data_i    (return_data),
    .complete_ready_o (complete_ready),
    .cmpl_base_addr_i (base),
    .wb               (wb_if.master),
    .cmpl_count_o     (cmpl_count),
    .overflow_o       (overflow)
`ifdef MP_CMPL_IRQ_EN
    ,
    .irq_valid_o      (irq_valid),
    .irq_ready_i      (irq_ready),
    .irq_pid_o        (irq_pid)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a;
    logic [63:0] d;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one record for one clock; optionally record what its write-back must look like.
  task automatic push_rec(input logic [8:0] pid, input logic [31:0] job,
                          input logic [63:0] exp_addr, input bit track);
    exp_t e;
    return_data   = {pid, job};
    complete_push = 1'b1;
    if (track) begin
      e.a = exp_addr;
      e.d = {1'b1, 22'b0, pid, job};
      q.push_back(e);
    end
    @(negedge clk);
    complete_push = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (wb_if.wb_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(tag, wb_if.wb_valid, 1'b1);
  endtask

  task automatic drain_one(input string tag);
    exp_t e;
    e = q.pop_front();
    wait_valid({tag, "_valid"});
    chk({tag, "_addr"}, wb_if.wb_addr, e.a);
    chk({tag, "_data"}, wb_if.wb_data, e.d);
    wb_if.wb_ready = 1'b1;
    @(negedge clk);
    wb_if.wb_ready = 1'b0;
    exp_cnt++;
    chk({tag, "_count"}, cmpl_count, exp_cnt);
    chk({tag, "_drop"}, wb_if.wb_valid, 1'b0);
  endtask

  initial begin
    exp_t e;
    rst_n = 1'b0; complete_push = 1'b0; return_data = '0;
    base = 64'h1000; wb_if.wb_ready = 1'b0;
`ifdef MP_CMPL_IRQ_EN
    irq_ready = 1'b1;
`endif
    repeat (2) @(negedge clk);
    chk("rst_valid", wb_if.wb_valid, 1'b0);
    chk("rst_ready", complete_ready, 1'b1);
    chk("rst_count", cmpl_count, 32'd0);
    chk("rst_ovf",   overflow, 1'b0);
    chk("rst_addr",  wb_if.wb_addr, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: single record, one-cycle pop latency
    push_rec(9'd5, 32'h1234_5678, 64'h1028, 1'b1);
    chk("t1_not_yet", wb_if.wb_valid, 1'b0);
    @(negedge clk);
    chk("t1_valid_n1", wb_if.wb_valid, 1'b1);
    chk("t1_data_lit", wb_if.wb_data, 64'h8000_0005_1234_5678);
    drain_one("t1");

    // 2: stalled write-back holds addr/data
    push_rec(9'd2, 32'h0000_CAFE, 64'h1010, 1'b1);
    wait_valid("t2_valid");
    e = q[0];
    for (int i = 0; i < 10; i++) begin
      chk("t2_hold_valid", wb_if.wb_valid, 1'b1);
      chk("t2_hold_addr",  wb_if.wb_addr, e.a);
      chk("t2_hold_data",  wb_if.wb_data, e.d);
      chk("t2_hold_count", cmpl_count, exp_cnt);
      @(negedge clk);
    end
    drain_one("t2");

    // 3: WB occupied by a blocker, then 17 pushes; the 17th must be dropped
    push_rec(9'd1, 32'h0000_00B0, 64'h1008, 1'b1);
    wait_valid("t3_blocker");
    for (int i = 0; i < 16; i++) begin
      chk("t3_ready_before", complete_ready, 1'b1);
      push_rec(9'(16 + i), 32'h3000 + 32'(i), 64'h1000 + 64'(8 * (16 + i)), 1'b1);
    end
    chk("t3_ready_full", complete_ready, 1'b0);
    chk("t3_ovf_before", overflow, 1'b0);
    push_rec(9'd40, 32'hDEAD_0017, 64'h0, 1'b0);
    chk("t3_ovf_after", overflow, 1'b1);
    while (q.size() > 0) drain_one("t3");
    chk("t3_ready_empty", complete_ready, 1'b1);

    // 4: push lands on the same edge the IDLE state pops, at FIFO count 8
    push_rec(9'd2, 32'h0000_4B00, 64'h1010, 1'b1);
    wait_valid("t4_blocker");
    for (int i = 0; i < 8; i++)
      push_rec(9'(50 + i), 32'h4000 + 32'(i), 64'h1000 + 64'(8 * (50 + i)), 1'b1);
    drain_one("t4_head");
`ifdef MP_CMPL_IRQ_EN
    @(negedge clk);
`endif
    push_rec(9'd60, 32'h0000_4444, 64'h11E0, 1'b1);
    chk("t4_reloaded", wb_if.wb_valid, 1'b1);
    for (int i = 0; i < 8; i++) begin
      chk("t4_ready_before", complete_ready, 1'b1);
      push_rec(9'(70 + i), 32'h4100 + 32'(i), 64'h1000 + 64'(8 * (70 + i)), 1'b1);
    end
    chk("t4_ready_full", complete_ready, 1'b0);
    while (q.size() > 0) drain_one("t4");

    // 5: 64-bit address wrap
    base = 64'hFFFF_FFFF_FFFF_FFF8;
    push_rec(9'd511, 32'h0000_0511, 64'h0000_0000_0000_0FF0, 1'b1);
    drain_one("t5");
    base = 64'h1000;

`ifdef MP_CMPL_IRQ_EN
    // 6: interrupt gates the next record
    irq_ready = 1'b0;
    push_rec(9'd3, 32'h0000_0003, 64'h1018, 1'b1);
    push_rec(9'd7, 32'h0000_0007, 64'h1038, 1'b1);
    drain_one("t6_first");
    chk("t6_irq1_valid", irq_valid, 1'b1);
    chk("t6_irq1_pid",   irq_pid, 9'd3);
    for (int i = 0; i < 5; i++) begin
      chk("t6_wb_blocked", wb_if.wb_valid, 1'b0);
      chk("t6_irq_held",   irq_valid, 1'b1);
      @(negedge clk);
    end
    irq_ready = 1'b1;
    @(negedge clk);
    irq_ready = 1'b0;
    chk("t6_irq1_done", irq_valid, 1'b0);
    drain_one("t6_second");
    chk("t6_irq2_valid", irq_valid, 1'b1);
    chk("t6_irq2_pid",   irq_pid, 9'd7);
    irq_ready = 1'b1;
    @(negedge clk);
    chk("t6_irq2_done", irq_valid, 1'b0);
`endif

    // 7: asynchronous reset mid write-back flushes everything
    push_rec(9'd1, 32'h7001, 64'h0, 1'b0);
    push_rec(9'd2, 32'h7002, 64'h0, 1'b0);
    push_rec(9'd3, 32'h7003, 64'h0, 1'b0);
    wait_valid("t7_valid");
    #3 rst_n = 1'b0;
    #1;
    chk("t7_valid",  wb_if.wb_valid, 1'b0);
    chk("t7_addr",   wb_if.wb_addr, 64'd0);
    chk("t7_data",   wb_if.wb_data, 64'd0);
    chk("t7_count",  cmpl_count, 32'd0);
    chk("t7_ovf",    overflow, 1'b0);
    chk("t7_ready",  complete_ready, 1'b1);
`ifdef MP_CMPL_IRQ_EN
    chk("t7_irq",    irq_valid, 1'b0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 0;
    repeat (5) @(negedge clk);
    chk("t7_fifo_empty", wb_if.wb_valid, 1'b0);
    push_rec(9'd9, 32'h0000_0099, 64'h1048, 1'b1);
    drain_one("t7_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
